// File: rtl/square_fixed_point_pkg.sv
// Shared types and constants for the fixed-point squarer and its multiplier.
package square_fixed_point_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_PROD_W = 2 * DEF_DATA_W;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Unsigned W x W iterative shift-add multiplier, one multiplier bit per clock.
// done_o is high during the final iteration; prod_o then already carries the
// complete product, so the caller can capture it on that same edge.
module seq_shift_add_mul
  import square_fixed_point_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = clog2(W);
  localparam int PW = 2 * W;

  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [PW-1:0] acc_q, acc_d, addend;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          last;

  // Partial product for this bit: multiplicand weighted by the bit position.
  always_comb begin
    addend = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
    acc_d  = acc_q + addend;
    last   = busy_q && (cnt_q == CW'(W - 1));
  end

  assign done_o = last;
  assign prod_o = acc_d;

  // Load on start, then accumulate one bit per clock for W clocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/square_fixed_point.sv
// Sequential fixed-point squarer: o_data = sat((i_data*i_data) >> FRAC_W).
// Build option SQUARE_FIXED_POINT_ROUND_EN selects round-half-up instead of
// truncation; latency and handshake are the same either way.
module square_fixed_point
  import square_fixed_point_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW-1:0] MAXV = {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
`ifdef SQUARE_FIXED_POINT_ROUND_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);
`endif

  state_e            state_q;
  logic              ready_q, valid_q, ovf_q;
  logic [DATA_W-1:0] data_q;

  logic              start;
  logic              mul_done;
  logic [PW-1:0]     mul_prod;
  logic [PW-1:0]     rnd, sh;
  logic [DATA_W-1:0] res_d;
  logic              ovf_d;

  assign start = (state_q == IDLE) && i_valid;

  seq_shift_add_mul #(.W(DATA_W)) u_mul (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .start_i (start),
    .a_i     (i_data),
    .b_i     (i_data),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Scale back to the input Q format, then clamp to DATA_W bits.
  always_comb begin
`ifdef SQUARE_FIXED_POINT_ROUND_EN
    rnd = mul_prod + HALF;
`else
    rnd = mul_prod;
`endif
    sh    = rnd >> FRAC_W;
    ovf_d = (sh > MAXV);
    res_d = ovf_d ? '1 : sh[DATA_W-1:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          state_q <= CALC;
          ready_q <= 1'b0;
        end
        CALC: if (mul_done) begin
          state_q <= DONE;
          valid_q <= 1'b1;
          data_q  <= res_d;
          ovf_q   <= ovf_d;
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_square_fixed_point.sv
// Scoreboard bench for square_fixed_point (DATA_W=8, FRAC_W=4).
module tb_square_fixed_point;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_ready = 1'b1;
  logic       o_ready, o_valid, o_overflow;
  logic [7:0] o_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [8:0] exp_q[$];   // {overflow, data}
  int         acc_q[$];   // accept cycle per operand

  square_fixed_point dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: real-valued square in Q4.4, rounded or truncated, clamped.
  function automatic logic [8:0] model(input int x);
    int p;
`ifdef SQUARE_FIXED_POINT_ROUND_EN
    p = (x * x + 8) / 16;
`else
    p = (x * x) / 16;
`endif
    if (p > 255) return {1'b1, 8'hFF};
    return {1'b0, p[7:0]};
  endfunction

  task automatic send(input logic [7:0] x);
    int n = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = x;
    while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
    if (!o_ready) begin
      chk("accept timeout", 0, 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    exp_q.push_back(model(int'(x)));
    acc_q.push_back(cyc);
    last_acc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge i_clk); n++; end
    chk("drain timeout", exp_q.size(), 0);
  endtask

  // Monitor: latency, hold-under-stall and result checks.
  logic       pv = 1'b0, phs = 1'b0, ho = 1'b0;
  logic [7:0] hd = '0;
  always begin
    @(negedge i_clk);
    #1;
    if (!i_reset) begin
      if (o_valid && !pv) begin
        if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), 8);
        else chk("unexpected valid", 1, 0);
      end
      if (o_valid && pv && !phs) begin
        chk("hold data", o_data, hd);
        chk("hold ovf", o_overflow, ho);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("result data", o_data, e[7:0]);
          chk("result ovf", o_overflow, e[8]);
        end else chk("unexpected result", 1, 0);
      end
    end
    pv  = o_valid && !i_reset;
    phs = o_valid && i_ready;
    hd  = o_data;
    ho  = o_overflow;
  end

  logic [7:0] dir[7] = '{8'h20, 8'h18, 8'h3F, 8'h03, 8'h40, 8'hFF, 8'h00};

  initial begin
    int prev;
    int n;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset ready", o_ready, 1);
    chk("reset valid", o_valid, 0);
    chk("reset data", o_data, 0);
    chk("reset ovf", o_overflow, 0);
    i_reset = 1'b0;

    // Directed corners back to back; also checks DATA_W+2 throughput.
    for (int i = 0; i < 7; i++) begin
      prev = last_acc;
      send(dir[i]);
      if (i > 0) chk("throughput", last_acc - prev, 10);
    end
    drain();

    // Back-pressure: result held, no accept, extra i_valid pulses ignored.
    i_ready = 1'b0;
    send(8'h18);
    n = 0;
    while (!o_valid && n < 50) begin @(negedge i_clk); n++; end
    chk("stall valid seen", o_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("stall ready", o_ready, 0);
      chk("stall valid", o_valid, 1);
      i_valid = 1'b1;
      i_data  = 8'($urandom);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("post hs valid", o_valid, 0);
    chk("post hs ready", o_ready, 1);
    drain();

    // Reset three edges into CALC aborts the operation.
    send(8'h20);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("abort valid", o_valid, 0);
    chk("abort ready", o_ready, 1);
    chk("abort data", o_data, 0);
    send(8'h20);
    drain();

    // Randomized operands.
    for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
    drain();

    repeat (3) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
